// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - 32x32 shift-add multiplier borrowing a shared 64-bit ALU
module mul_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    output logic         busy,
    output logic         done,
    output logic [31:0]  hi,
    output logic [31:0]  lo,
    output logic         alu_req,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_y
);

    localparam logic [3:0] ALU_ADD = 4'b1010;
    localparam logic [3:0] ALU_SUB = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state;
    logic [N-1:0] acc;
    logic [N-1:0] mcand;
    logic [31:0]  mplier;
    logic [4:0]   cnt;
    logic         neg;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign alu_req = (state == ITER) || (state == FIX);

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = 4'b0000;
        case (state)
            ITER: begin
                alu_a       = acc;
                alu_b       = mplier[0] ? mcand : '0;
                alu_control = ALU_ADD;
            end
            FIX: begin
                if (neg) begin
                    alu_a       = '0;
                    alu_b       = acc;
                    alu_control = ALU_SUB;
                end else begin
                    alu_a       = acc;
                    alu_b       = '0;
                    alu_control = ALU_ADD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{(N-32){1'b0}}, magnitude(a, is_signed)};
                        mplier <= magnitude(b, is_signed);
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= is_signed & (a[31] ^ b[31]);
                        state  <= ITER;
                    end
                end
                ITER: begin
                    acc    <= alu_y;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    acc   <= alu_y;
                    hi    <= alu_y[63:32];
                    lo    <= alu_y[31:0];
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
